// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter
//   Round-robin arbiter and command sequencer for the RW port (port 0) of a
//   1rw1r OpenRAM macro. One requester is granted at a time. The block drives
//   the macro's registered-input command pins and captures read data in the
//   cycle after issue, before the macro's dout hold window closes.
//
//   Optional feature macro: SRAM_ARB_INIT_EN. When it is defined, the block
//   zero-fills the whole array after reset before it accepts any request.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req0/1, we0/1                   request and write select (1 = write)
//   wmask0_i/1_i, addr0_i/1_i,
//   wdata0_i/1_i                    per-requester command fields
//   gnt0/1                          one-cycle grant pulse
//   rvalid0/1, rdata                one-cycle read-valid pulse, shared data
//   busy                            high whenever the FSM is not idle
//   sram_csb0, sram_web0, sram_wmask0,
//   sram_addr0, sram_din0           macro command (registered)
//   sram_dout0                      macro read data
module sram_rw_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [NUM_WMASKS-1:0] wmask0_i,
   input  logic [NUM_WMASKS-1:0] wmask1_i,
   input  logic [ADDR_WIDTH-1:0] addr0_i,
   input  logic [ADDR_WIDTH-1:0] addr1_i,
   input  logic [DATA_WIDTH-1:0] wdata0_i,
   input  logic [DATA_WIDTH-1:0] wdata1_i,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t state, state_n;
   logic   last, last_n;     // requester granted most recently
   logic   owner, owner_n;   // requester of the in-flight operation
   logic   win;

   logic                  csb_n, web_n, gnt0_n, gnt1_n, rv0_n, rv1_n, busy_n;
   logic [NUM_WMASKS-1:0] wmask_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] din_n, rdata_n;

   // Under contention the requester that did not win last time goes next.
   assign win = (req0 && req1) ? ~last : req1;

   // State and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef SRAM_ARB_INIT_EN
         state <= S_INIT;
         busy  <= 1'b1;
`else
         state <= S_IDLE;
         busy  <= 1'b0;
`endif
         last        <= 1'b1;
         owner       <= 1'b0;
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata       <= '0;
      end else begin
         state       <= state_n;
         busy        <= busy_n;
         last        <= last_n;
         owner       <= owner_n;
         sram_csb0   <= csb_n;
         sram_web0   <= web_n;
         sram_wmask0 <= wmask_n;
         sram_addr0  <= addr_n;
         sram_din0   <= din_n;
         gnt0        <= gnt0_n;
         gnt1        <= gnt1_n;
         rvalid0     <= rv0_n;
         rvalid1     <= rv1_n;
         rdata       <= rdata_n;
      end
   end

   // Next state
   always_comb begin
      state_n = state;
      case (state)
         // Init is done once the top address has been written.
         S_INIT:  if (!sram_csb0 && (&sram_addr0)) state_n = S_IDLE;
         S_IDLE:  if (req0 || req1) state_n = S_ISSUE;
         // web0 still holds the issued command: high means a read.
         S_ISSUE: state_n = sram_web0 ? S_WAIT : S_IDLE;
         S_WAIT:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      csb_n   = 1'b1;
      web_n   = 1'b1;
      wmask_n = sram_wmask0;
      addr_n  = sram_addr0;
      din_n   = sram_din0;
      gnt0_n  = 1'b0;
      gnt1_n  = 1'b0;
      rv0_n   = 1'b0;
      rv1_n   = 1'b0;
      rdata_n = rdata;
      last_n  = last;
      owner_n = owner;
      busy_n  = (state_n != S_IDLE);
      case (state)
         S_INIT: begin
            if (state_n != S_IDLE) begin
               csb_n   = 1'b0;
               web_n   = 1'b0;
               wmask_n = '1;
               din_n   = '0;
               // First init cycle still shows the reset command (csb0 high).
               addr_n  = sram_csb0 ? '0 : sram_addr0 + ADDR_WIDTH'(1);
            end
         end
         S_IDLE: begin
            if (req0 || req1) begin
               csb_n   = 1'b0;
               web_n   = win ? ~we1 : ~we0;
               wmask_n = win ? wmask1_i : wmask0_i;
               addr_n  = win ? addr1_i : addr0_i;
               din_n   = win ? wdata1_i : wdata0_i;
               gnt0_n  = ~win;
               gnt1_n  = win;
               last_n  = win;
               owner_n = win;
            end
         end
         S_WAIT: begin
            rdata_n = sram_dout0;
            rv0_n   = ~owner;
            rv1_n   = owner;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: a behavioural macro model on the port plus a
// reference of memory contents and round-robin order kept at transaction level.
module tb_sram_rw_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [3:0]  wmask0_i = 0, wmask1_i = 0;
   logic [7:0]  addr0_i = 0, addr1_i = 0;
   logic [31:0] wdata0_i = 0, wdata1_i = 0;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy;
   logic [31:0] rdata;
   logic        sram_csb0, sram_web0;
   logic [3:0]  sram_wmask0;
   logic [7:0]  sram_addr0;
   logic [31:0] sram_din0, sram_dout0;

   sram_rw_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .wmask0_i(wmask0_i), .wmask1_i(wmask1_i),
      .addr0_i(addr0_i), .addr1_i(addr1_i),
      .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   always #5 clk = ~clk;

   // Macro model: command sampled at posedge, array access at the following
   // negedge, dout goes invalid shortly after the next posedge.
   logic [31:0] mem [256];
   logic        l_csb = 1'b1, l_web = 1'b1;
   logic [7:0]  l_a;
   logic [31:0] l_d;
   logic [3:0]  l_m;
   initial sram_dout0 = 'x;
   always @(posedge clk) begin
      l_csb <= sram_csb0; l_web <= sram_web0; l_a <= sram_addr0;
      l_d <= sram_din0; l_m <= sram_wmask0;
      #1 sram_dout0 = 'x;
   end
   always @(negedge clk) begin
      if (!l_csb) begin
         if (!l_web) begin
            for (int b = 0; b < 4; b++)
               if (l_m[b]) mem[l_a][8*b +: 8] = l_d[8*b +: 8];
         end else sram_dout0 = mem[l_a];
      end
   end

   // Reference state
   logic [31:0] ref_mem [256];
   int          ptr = 1;   // requester granted last
   logic        p_valid [2] = '{0, 0};
   logic        p_we [2];
   logic [7:0]  p_addr [2];
   logic [31:0] p_data [2];
   logic [3:0]  p_mask [2];
   int vectors = 0, miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      req0 = p_valid[0]; we0 = p_we[0]; addr0_i = p_addr[0];
      wdata0_i = p_data[0]; wmask0_i = p_mask[0];
      req1 = p_valid[1]; we1 = p_we[1]; addr1_i = p_addr[1];
      wdata1_i = p_data[1]; wmask1_i = p_mask[1];
   endtask

   task automatic post(input int r, input logic we, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] m);
      p_valid[r] = 1; p_we[r] = we; p_addr[r] = a; p_data[r] = d; p_mask[r] = m;
   endtask

   // One arbitration round starting with the DUT idle at a negedge.
   task automatic round(output int w);
      logic [31:0] expd;
      drive();
      if (!p_valid[0] && !p_valid[1]) begin
         @(negedge clk);
         chk("idle_csb", sram_csb0, 1); chk("idle_busy", busy, 0);
         chk("idle_gnt", {gnt1, gnt0}, 0);
         w = -1;
         return;
      end
      w = (p_valid[0] && p_valid[1]) ? (ptr == 0 ? 1 : 0) : (p_valid[0] ? 0 : 1);
      ptr = w;
      @(negedge clk);
      chk("gnt0", gnt0, w == 0); chk("gnt1", gnt1, w == 1);
      chk("csb_issue", sram_csb0, 0); chk("addr", sram_addr0, p_addr[w]);
      chk("web", sram_web0, !p_we[w]);
      if (p_we[w]) begin
         chk("din", sram_din0, p_data[w]); chk("wmask", sram_wmask0, p_mask[w]);
      end
      p_valid[w] = 0;
      drive();
      if (p_we[w]) begin
         for (int b = 0; b < 4; b++)
            if (p_mask[w][b]) ref_mem[p_addr[w]][8*b +: 8] = p_data[w][8*b +: 8];
         @(negedge clk);
         chk("wr_done_csb", sram_csb0, 1); chk("wr_done_busy", busy, 0);
         chk("wr_done_gnt", {gnt1, gnt0}, 0);
      end else begin
         expd = ref_mem[p_addr[w]];
         @(negedge clk);
         chk("wait_rv", {rvalid1, rvalid0}, 0); chk("wait_busy", busy, 1);
         chk("wait_csb", sram_csb0, 1);
         @(negedge clk);
         chk("rvalid0", rvalid0, w == 0); chk("rvalid1", rvalid1, w == 1);
         chk("rdata", rdata, expd); chk("rd_done_busy", busy, 0);
         chk("rd_gnt", {gnt1, gnt0}, 0);
      end
   endtask

   task automatic wait_init();
`ifdef SRAM_ARB_INIT_EN
      req0 = 1; we0 = 0; addr0_i = 8'hFF;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         chk("init_busy", busy, 1); chk("init_gnt0", gnt0, 0);
      end
      req0 = 0;
      for (int i = 0; i < 8 && busy; i++) @(negedge clk);
      chk("init_done", busy, 0);
      for (int i = 0; i < 256; i++) ref_mem[i] = 0;
`endif
   endtask

   task automatic check_reset();
      chk("rst_csb", sram_csb0, 1); chk("rst_web", sram_web0, 1);
      chk("rst_wmask", sram_wmask0, 0); chk("rst_addr", sram_addr0, 0);
      chk("rst_din", sram_din0, 0); chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_rv", {rvalid1, rvalid0}, 0); chk("rst_rdata", rdata, 0);
`ifdef SRAM_ARB_INIT_EN
      chk("rst_busy", busy, 1);
`else
      chk("rst_busy", busy, 0);
`endif
   endtask

   initial begin
      int w;
      repeat (2) @(negedge clk);
      check_reset();
      rst_n = 1;
      wait_init();
`ifdef SRAM_ARB_INIT_EN
      post(0, 0, 8'hFF, 0, 0); round(w);
      chk("init_rd_ff", rdata, 32'h0);
`endif
      // Idle hold
      for (int i = 0; i < 10; i++) round(w);

      // Single write then read
      post(0, 1, 8'h10, 32'hDEADBEEF, 4'hF); round(w);
      post(0, 0, 8'h10, 0, 0); round(w);
      chk("wr_rd_data", rdata, 32'hDEADBEEF);

      // Byte mask
      post(0, 1, 8'h20, 32'h11223344, 4'hF); round(w);
      post(1, 1, 8'h20, 32'hAABBCCDD, 4'h5); round(w);
      post(0, 0, 8'h20, 0, 0); round(w);
      chk("mask_data", rdata, 32'h11BB33DD);

      // Preload the address range used below
      for (int a = 0; a < 16; a++) begin
         post(a % 2, 1, 8'(a), $urandom, 4'hF); round(w);
      end

      // Contention, both requests held continuously
      post(0, 0, 8'd3, 0, 0); post(1, 0, 8'd7, 0, 0); round(w);
      chk("cont_first", w, 0);
      post(0, 0, 8'd4, 0, 0); round(w); chk("cont_2", w, 1);
      post(1, 0, 8'd8, 0, 0); round(w); chk("cont_3", w, 0);
      round(w); chk("cont_4", w, 1);

      // Reset during WAIT of a read
      post(1, 0, 8'd5, 0, 0); drive();
      @(negedge clk); p_valid[1] = 0; drive();
      @(negedge clk);
      rst_n = 0;
      #1 check_reset();
      @(negedge clk);
      chk("rst_no_rv", {rvalid1, rvalid0}, 0);
      rst_n = 1; ptr = 1;
      wait_init();
      for (int a = 0; a < 16; a++) begin
         post(a % 2, 1, 8'(a), $urandom, 4'hF); round(w);
      end
      post(0, 0, 8'd1, 0, 0); post(1, 0, 8'd2, 0, 0); round(w);
      chk("post_rst_cont", w, 0);
      round(w);

      // Randomized traffic
      for (int n = 0; n < 120; n++) begin
         for (int r = 0; r < 2; r++)
            if (!p_valid[r] && ($urandom_range(3) != 0))
               post(r, 1'($urandom_range(1)), 8'($urandom_range(15)), $urandom,
                    4'($urandom_range(15)));
         round(w);
      end
      while (p_valid[0] || p_valid[1]) round(w);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Two-requester arbiter and sequencer for the RW port (port 0) of the 32x256 1rw1r OpenRAM macro. It grants one requester at a time using round-robin arbitration and drives the macro's registered-input command interface. It captures read data at the correct edge, before the macro's hold window expires. It sits between the user-project cores and the macro; macro port 1 (R) is wired directly at top level and is outside this block.

## Interface
Parameters:
- ADDR_WIDTH, 8, word address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-lane write-enable count (DATA_WIDTH/8)

Ports:
- clk  in  1  single clock; also drives macro clk0 at top level
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  request from requester 0 / 1
- we0, we1  in  1  1 = write, 0 = read
- wmask0_i, wmask1_i  in  NUM_WMASKS  byte write enables
- addr0_i, addr1_i  in  ADDR_WIDTH  word address
- wdata0_i, wdata1_i  in  DATA_WIDTH  write data
- gnt0, gnt1  out  1  one-cycle grant pulse
- rvalid0, rvalid1  out  1  one-cycle read-data-valid pulse
- rdata  out  DATA_WIDTH  read data shared by both requesters; qualify with rvalidN
- busy  out  1  high whenever state is not IDLE
- sram_csb0, sram_web0  out  1  to macro (active low)
- sram_wmask0  out  NUM_WMASKS  to macro
- sram_addr0  out  ADDR_WIDTH  to macro
- sram_din0  out  DATA_WIDTH  to macro
- sram_dout0  in  DATA_WIDTH  from macro

## Operation
- Every output is registered.
- Reset values: csb0=1, web0=1, wmask0=0, addr0=0, din0=0, gnt*=0, rvalid*=0, rdata=0, busy=0 (busy=1 with the init feature), last-grant pointer=1.
- FSM states: INIT (config only), IDLE, ISSUE, WAIT.
- IDLE:
  - If neither req is high, hold csb0=1.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not the last-grant pointer, then update the pointer. Requester 0 therefore wins the first contention after reset.
  - On a grant, register csb0=0, web0=~weN, wmask0, addr0 and din0 from the winner; pulse gntN; go to ISSUE.
- ISSUE: the macro samples the command at the posedge that ends this cycle. Next cycle drives csb0=1 and web0=1.
  - On a write, go to IDLE.
  - On a read, go to WAIT.
- WAIT: the macro updates dout0 after the negedge in this cycle. At the posedge ending WAIT, register rdata=sram_dout0, pulse rvalidN for the owner, and go to IDLE.
- Requester rule: hold req and its fields stable until gntN. In the gnt cycle, deassert req or present the next request. A req still high in the cycle after gnt is a new request.
- Read data is captured only in WAIT; the macro invalidates dout0 shortly after the next posedge.
- Write data is never read back through this block; a read of a just-written address returns the new data.
- Reset mid-operation clears outputs immediately and drops the in-flight operation. A write the macro has already sampled may still complete.

## Timing
- Read: req sampled in cycle 0 → gnt cycle 1 (csb0 low) → WAIT cycle 2 → rvalid+rdata cycle 3. Next grant is possible in cycle 4.
- Write: req cycle 0 → gnt cycle 1 (csb0 low) → IDLE cycle 2. Next grant is possible in cycle 3.
- Peak throughput: one read per 3 cycles, one write per 2 cycles.
- gnt and rvalid are never high in the same cycle for the same requester.

## Configuration
- SRAM_ARB_INIT_EN defined:
  - After reset release, the FSM starts in INIT.
  - INIT drives csb0=0, web0=0, wmask0=all ones and din0=0, and increments addr0 each cycle from 0 to 2^ADDR_WIDTH-1. That is 256 consecutive write cycles.
  - After the last address, INIT goes to IDLE.
  - busy=1 throughout INIT; req is ignored and no gnt is issued.
- SRAM_ARB_INIT_EN undefined: reset goes directly to IDLE. Memory contents are undefined until written.

## Test plan
- Single write then read: req0 write addr 0x10, data 0xDEADBEEF, wmask 0xF; then req0 read 0x10. Expect gnt0 at cycle 1 of each request, rvalid0 3 cycles after the read req, rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 to 0x20, then 0xAABBCCDD with wmask 0x5, then read 0x20. Expect 0x11BB33DD.
- Contention: req0 and req1 high together, held continuously. Expect grants alternating 0,1,0,1 starting with requester 0. Each read returns its own data on the matching rvalid.
- Reset during WAIT: assert rst_n low in the WAIT cycle of a read. Expect no rvalid and all outputs at reset values immediately. After release, the first contention grants requester 0.
- Init (SRAM_ARB_INIT_EN): busy high for 256 cycles after reset and req0 ignored. Then a read of 0xFF returns 0x00000000 with rvalid0.
- Idle hold: no req for 10 cycles. Expect csb0=1, busy=0, gnt*=0.
